// File: rtl/music_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : music_pkg
//  Description : Shared types, entry field layout, end-marker rule, note table
//                and song contents for the note sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package music_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_LOAD  = 3'd2,
        ST_PLAY  = 3'd3,
        ST_PAUSE = 3'd4
    } seq_state_t;

    localparam int ENTRY_W  = 16;
    localparam int ADDR_W   = 8;
    localparam int POS_W    = 6;
    localparam int HZ_W     = 12;
    localparam int NOTE_MSB = 15;
    localparam int NOTE_LSB = 10;
    localparam int DUR_MSB  = 9;
    localparam int DUR_LSB  = 4;

    function automatic logic [5:0] entry_note(input logic [ENTRY_W-1:0] e);
        return e[NOTE_MSB:NOTE_LSB];
    endfunction

    function automatic logic [5:0] entry_dur(input logic [ENTRY_W-1:0] e);
        return e[DUR_MSB:DUR_LSB];
    endfunction

    function automatic logic is_end(input logic [ENTRY_W-1:0] e);
        return entry_dur(e) == 6'd0;
    endfunction

    // C3..B6 equal-tempered (A4 = code 22 = 440 Hz), rounded to nearest Hz
    function automatic logic [HZ_W-1:0] note_hz(input logic [5:0] code);
        logic [HZ_W-1:0] hz;
        case (code)
            6'd1:  hz = 12'd131;  6'd2:  hz = 12'd139;  6'd3:  hz = 12'd147;  6'd4:  hz = 12'd156;
            6'd5:  hz = 12'd165;  6'd6:  hz = 12'd175;  6'd7:  hz = 12'd185;  6'd8:  hz = 12'd196;
            6'd9:  hz = 12'd208;  6'd10: hz = 12'd220;  6'd11: hz = 12'd233;  6'd12: hz = 12'd247;
            6'd13: hz = 12'd262;  6'd14: hz = 12'd277;  6'd15: hz = 12'd294;  6'd16: hz = 12'd311;
            6'd17: hz = 12'd330;  6'd18: hz = 12'd349;  6'd19: hz = 12'd370;  6'd20: hz = 12'd392;
            6'd21: hz = 12'd415;  6'd22: hz = 12'd440;  6'd23: hz = 12'd466;  6'd24: hz = 12'd494;
            6'd25: hz = 12'd523;  6'd26: hz = 12'd554;  6'd27: hz = 12'd587;  6'd28: hz = 12'd622;
            6'd29: hz = 12'd659;  6'd30: hz = 12'd698;  6'd31: hz = 12'd740;  6'd32: hz = 12'd784;
            6'd33: hz = 12'd831;  6'd34: hz = 12'd880;  6'd35: hz = 12'd932;  6'd36: hz = 12'd988;
            6'd37: hz = 12'd1047; 6'd38: hz = 12'd1109; 6'd39: hz = 12'd1175; 6'd40: hz = 12'd1245;
            6'd41: hz = 12'd1319; 6'd42: hz = 12'd1397; 6'd43: hz = 12'd1480; 6'd44: hz = 12'd1568;
            6'd45: hz = 12'd1661; 6'd46: hz = 12'd1760; 6'd47: hz = 12'd1865; 6'd48: hz = 12'd1976;
            default: hz = 12'd0;
        endcase
        return hz;
    endfunction

    function automatic logic [ENTRY_W-1:0] make_entry(input logic [5:0] note, input logic [5:0] dur);
        return {note, dur, 4'hF};
    endfunction

    // Unlisted words are zero, which reads as an end marker
    function automatic logic [ENTRY_W-1:0] song_word(input logic [ADDR_W-1:0] addr);
        logic [ENTRY_W-1:0] w;
        case (addr)
            8'h00:   w = make_entry(6'd22, 6'd3);
            8'h40:   w = make_entry(6'd13, 6'd1);
            8'h41:   w = make_entry(6'd17, 6'd1);
            8'hC0:   w = make_entry(6'd0,  6'd2);
            8'hC1:   w = make_entry(6'd10, 6'd1);
            8'hC2:   w = make_entry(6'd22, 6'd0);
            default: w = '0;
        endcase
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/note_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : note_sequencer_if
//  Description : Transport controls and tone/status outputs of the sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
interface note_sequencer_if;
    import music_pkg::*;

    logic              play;
    logic              pause;
    logic              stop;
    logic              loop;
    logic [1:0]        song_sel;
    logic [1:0]        tempo_sel;
    logic [HZ_W-1:0]   hz_next;
    logic [5:0]        note_idx;
    logic              playing;
    logic              done;

    modport master (
        output play, pause, stop, loop, song_sel, tempo_sel,
        input  hz_next, note_idx, playing, done
    );

    modport slave (
        input  play, pause, stop, loop, song_sel, tempo_sel,
        output hz_next, note_idx, playing, done
    );
endinterface
`default_nettype wire

// File: rtl/song_rom.sv
`default_nettype none
// ============================================================================
//  Module      : song_rom
//  Description : 4 songs x 64 entries x 16 bit, synchronous read, 1-cycle latency.
//  Revision    : 1.0 - initial release
// ============================================================================
module song_rom
    import music_pkg::*;
(
    input  logic               clk,
    input  logic [ADDR_W-1:0]  i_addr,
    output logic [ENTRY_W-1:0] o_data
);
    logic [ENTRY_W-1:0] data_q;

    always_ff @(posedge clk) begin
        data_q <= song_word(i_addr);
    end

    assign o_data = data_q;
endmodule
`default_nettype wire

// File: rtl/note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : note_sequencer
//  Description : Steps through a stored song and requests one tone per entry.
//  Revision    : 1.0 - initial release
// ============================================================================
module note_sequencer
    import music_pkg::*;
#(
    parameter int CLK_HZ   = 100_000_000,
    parameter int UNIT_CYC = 12_500_000,
    parameter int GAP_CYC  = 1_000_000
) (
    input  logic             clk,
    input  logic             rst_n,
    note_sequencer_if.slave  bus
);
    localparam int          CNT_W = $clog2(63 * 2 * UNIT_CYC + 1);
    localparam logic [63:0] GAP_L = 64'(GAP_CYC);

    if (UNIT_CYC < 2 || GAP_CYC < 0 || CLK_HZ < UNIT_CYC) begin : g_param_check
        $error("note_sequencer: inconsistent timing parameters");
    end

    seq_state_t         state_q, state_d, resume_q, resume_d;
    logic [1:0]         song_q, song_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [5:0]         note_idx_q, note_idx_d;
    logic [HZ_W-1:0]    hz_next_q, hz_next_d;
    logic               playing_q, playing_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   w_unit;
    logic [ENTRY_W-1:0] w_rom_data;

    song_rom u_rom (
        .clk    (clk),
        .i_addr ({song_q, pos_q}),
        .o_data (w_rom_data)
    );

    always_comb begin
        case (bus.tempo_sel)
            2'b01:   w_unit = CNT_W'(UNIT_CYC / 2);
            2'b10:   w_unit = CNT_W'(UNIT_CYC * 2);
            default: w_unit = CNT_W'(UNIT_CYC);
        endcase
    end

    always_comb begin
        state_d    = state_q;
        resume_d   = resume_q;
        song_d     = song_q;
        pos_d      = pos_q;
        cnt_d      = cnt_q;
        note_idx_d = note_idx_q;
        done_d     = 1'b0;

        if (bus.stop) begin
            state_d    = ST_IDLE;
            pos_d      = '0;
            cnt_d      = '0;
            note_idx_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.play && !bus.pause) begin
                        state_d = ST_FETCH;
                        song_d  = bus.song_sel;
                        pos_d   = '0;
                    end
                end
                ST_FETCH: state_d = ST_LOAD;
                ST_LOAD: begin
                    if (is_end(w_rom_data)) begin
                        pos_d = '0;
                        if (bus.loop) begin
                            state_d = ST_FETCH;
                        end else begin
                            state_d    = ST_IDLE;
                            done_d     = 1'b1;
                            note_idx_d = '0;
                        end
                    end else begin
                        state_d    = ST_PLAY;
                        note_idx_d = entry_note(w_rom_data);
                        cnt_d      = CNT_W'(entry_dur(w_rom_data)) * w_unit;
                    end
                end
                ST_PLAY: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_FETCH;
                        pos_d   = pos_q + POS_W'(1);
                    end
                end
                ST_PAUSE: begin
                    if (bus.play) state_d = resume_q;
                end
                default: state_d = ST_IDLE;
            endcase

            // The pausing PLAY cycle still counts as elapsed, so the note keeps
            // its exact length; FETCH/LOAD drop their read and redo it on resume.
            if (bus.pause && state_q inside {ST_FETCH, ST_LOAD, ST_PLAY}) begin
                resume_d = (state_q == ST_PLAY) ? state_d : ST_FETCH;
                state_d  = ST_PAUSE;
                if (state_q != ST_PLAY) begin
                    pos_d      = pos_q;
                    cnt_d      = cnt_q;
                    note_idx_d = note_idx_q;
                    done_d     = 1'b0;
                end
            end
        end

        playing_d = state_d inside {ST_FETCH, ST_LOAD, ST_PLAY};
        hz_next_d = (state_d == ST_PLAY && 64'(cnt_d) > GAP_L) ? note_hz(note_idx_d) : '0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            resume_q   <= ST_IDLE;
            song_q     <= '0;
            pos_q      <= '0;
            cnt_q      <= '0;
            note_idx_q <= '0;
            hz_next_q  <= '0;
            playing_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            resume_q   <= resume_d;
            song_q     <= song_d;
            pos_q      <= pos_d;
            cnt_q      <= cnt_d;
            note_idx_q <= note_idx_d;
            hz_next_q  <= hz_next_d;
            playing_q  <= playing_d;
            done_q     <= done_d;
        end
    end

    assign bus.hz_next  = hz_next_q;
    assign bus.note_idx = note_idx_q;
    assign bus.playing  = playing_q;
    assign bus.done     = done_q;
endmodule
`default_nettype wire

// File: tb/tb_note_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_note_sequencer
//  Description : Directed self-checking bench, UNIT_CYC=10 and GAP_CYC=2.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_note_sequencer;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    note_sequencer_if sif ();

    note_sequencer #(.UNIT_CYC(10), .GAP_CYC(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.slave)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_play();
        sif.play = 1'b1;
        step(1);
        sif.play = 1'b0;
    endtask

    // Cycle n = 0 is the FETCH cycle right after play is sampled
    task automatic measure(input logic [11:0] hz_exp, input int budget, input int probe_n,
                           output int snd, output int first_snd, output int done_at,
                           output int bad_hz, output logic [5:0] probe_note);
        snd = 0; first_snd = -1; done_at = -1; bad_hz = 0; probe_note = '1;
        for (int n = 0; n < budget; n++) begin
            if (n == probe_n) probe_note = sif.note_idx;
            if (sif.hz_next != 12'd0) begin
                if (sif.hz_next != hz_exp) bad_hz++;
                else begin
                    snd++;
                    if (first_snd < 0) first_snd = n;
                end
            end
            if (sif.done === 1'b1) begin
                done_at = n;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step(3);
        checks++; if (sif.hz_next !== 12'd0) begin errors++; $display("FAIL reset_hz: got %0d want 0", sif.hz_next); end
        checks++; if (sif.note_idx !== 6'd0) begin errors++; $display("FAIL reset_note: got %0d want 0", sif.note_idx); end
        checks++; if (sif.playing !== 1'b0) begin errors++; $display("FAIL reset_playing: got %b want 0", sif.playing); end
        checks++; if (sif.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", sif.done); end
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_tempo(input logic [1:0] tsel, input int exp_snd, input int exp_done);
        int snd, first_snd, done_at, bad_hz;
        logic [5:0] pn;
        sif.song_sel = 2'd0; sif.tempo_sel = tsel;
        pulse_play();
        measure(12'd440, 120, 3, snd, first_snd, done_at, bad_hz, pn);
        checks++; if (snd != exp_snd) begin errors++; $display("FAIL tempo%0d_sounded: got %0d want %0d", tsel, snd, exp_snd); end
        checks++; if (first_snd != 2) begin errors++; $display("FAIL tempo%0d_first: got %0d want 2", tsel, first_snd); end
        checks++; if (done_at != exp_done) begin errors++; $display("FAIL tempo%0d_done_at: got %0d want %0d", tsel, done_at, exp_done); end
        checks++; if (bad_hz != 0) begin errors++; $display("FAIL tempo%0d_bad_hz: got %0d want 0", tsel, bad_hz); end
        checks++; if (pn !== 6'd22) begin errors++; $display("FAIL tempo%0d_note_idx: got %0d want 22", tsel, pn); end
        checks++; if (sif.playing !== 1'b0 || sif.hz_next !== 12'd0) begin errors++; $display("FAIL tempo%0d_idle: playing %b hz %0d want 0/0", tsel, sif.playing, sif.hz_next); end
        step(1);
        checks++; if (sif.done !== 1'b0) begin errors++; $display("FAIL tempo%0d_done_pulse: got %b want 0", tsel, sif.done); end
        sif.tempo_sel = 2'd0;
    endtask

    task automatic test_pause();
        int snd1 = 0, quiet_bad = 0, snd2, first2, done2, bad2;
        logic [5:0] pn;
        sif.song_sel = 2'd0;
        pulse_play();
        for (int n = 0; n <= 6; n++) begin
            if (sif.hz_next == 12'd440) snd1++;
            if (n < 6) step(1);
        end
        sif.pause = 1'b1;
        step(1);
        sif.pause = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (sif.hz_next != 12'd0 || sif.playing != 1'b0 || sif.done != 1'b0) quiet_bad++;
            step(1);
        end
        pulse_play();
        measure(12'd440, 80, 0, snd2, first2, done2, bad2, pn);
        checks++; if (snd1 != 5) begin errors++; $display("FAIL pause_before: got %0d want 5", snd1); end
        checks++; if (quiet_bad != 0) begin errors++; $display("FAIL pause_quiet: got %0d want 0", quiet_bad); end
        checks++; if (first2 != 0) begin errors++; $display("FAIL pause_resume_first: got %0d want 0", first2); end
        checks++; if (snd1 + snd2 != 28) begin errors++; $display("FAIL pause_total: got %0d want 28", snd1 + snd2); end
        checks++; if (done2 != 27) begin errors++; $display("FAIL pause_done_at: got %0d want 27", done2); end
        step(1);
    endtask

    task automatic test_loop();
        logic [11:0] hz_at [0:41];
        int done_cnt = 0;
        sif.song_sel = 2'd1; sif.loop = 1'b1;
        pulse_play();
        for (int n = 0; n <= 41; n++) begin
            hz_at[n] = sif.hz_next;
            if (sif.done === 1'b1) done_cnt++;
            if (n < 41) step(1);
        end
        sif.stop = 1'b1;
        step(1);
        sif.stop = 1'b0;
        checks++; if (hz_at[2] !== 12'd262) begin errors++; $display("FAIL loop_n2: got %0d want 262", hz_at[2]); end
        checks++; if (hz_at[10] !== 12'd0) begin errors++; $display("FAIL loop_gap: got %0d want 0", hz_at[10]); end
        checks++; if (hz_at[14] !== 12'd330) begin errors++; $display("FAIL loop_n14: got %0d want 330", hz_at[14]); end
        checks++; if (hz_at[28] !== 12'd262) begin errors++; $display("FAIL loop_repeat1: got %0d want 262", hz_at[28]); end
        checks++; if (hz_at[40] !== 12'd330) begin errors++; $display("FAIL loop_repeat2: got %0d want 330", hz_at[40]); end
        checks++; if (done_cnt != 0) begin errors++; $display("FAIL loop_done: got %0d want 0", done_cnt); end
        checks++; if (sif.hz_next !== 12'd0 || sif.playing !== 1'b0 || sif.done !== 1'b0) begin errors++; $display("FAIL loop_stop: hz %0d playing %b done %b want 0/0/0", sif.hz_next, sif.playing, sif.done); end
        sif.loop = 1'b0;
        step(3);
        checks++; if (sif.playing !== 1'b0) begin errors++; $display("FAIL loop_stop_idle: got %b want 0", sif.playing); end
    endtask

    task automatic test_empty();
        int nz = 0, done_at = -1;
        logic play0 = 1'b0;
        sif.song_sel = 2'd2;
        pulse_play();
        for (int n = 0; n < 6; n++) begin
            if (n == 0) play0 = sif.playing;
            if (sif.hz_next != 12'd0) nz++;
            if (sif.done === 1'b1 && done_at < 0) done_at = n;
            step(1);
        end
        checks++; if (play0 !== 1'b1) begin errors++; $display("FAIL empty_playing: got %b want 1", play0); end
        checks++; if (done_at != 2) begin errors++; $display("FAIL empty_done_at: got %0d want 2", done_at); end
        checks++; if (nz != 0) begin errors++; $display("FAIL empty_hz: got %0d want 0", nz); end
    endtask

    task automatic test_rest();
        int snd, first_snd, done_at, bad_hz;
        logic [5:0] pn;
        sif.song_sel = 2'd3;
        pulse_play();
        measure(12'd220, 80, 25, snd, first_snd, done_at, bad_hz, pn);
        checks++; if (first_snd != 24) begin errors++; $display("FAIL rest_first: got %0d want 24", first_snd); end
        checks++; if (snd != 8) begin errors++; $display("FAIL rest_sounded: got %0d want 8", snd); end
        checks++; if (bad_hz != 0) begin errors++; $display("FAIL rest_bad_hz: got %0d want 0", bad_hz); end
        checks++; if (pn !== 6'd10) begin errors++; $display("FAIL rest_note_idx: got %0d want 10", pn); end
        checks++; if (done_at != 36) begin errors++; $display("FAIL rest_done_at: got %0d want 36", done_at); end
        step(1);
    endtask

    task automatic test_priority();
        sif.song_sel = 2'd0;
        pulse_play();
        step(5);
        pulse_play();
        checks++; if (sif.hz_next !== 12'd440) begin errors++; $display("FAIL play_ignored: got %0d want 440", sif.hz_next); end
        sif.play = 1'b1; sif.pause = 1'b1; sif.stop = 1'b1;
        step(1);
        sif.play = 1'b0; sif.pause = 1'b0; sif.stop = 1'b0;
        checks++; if (sif.hz_next !== 12'd0 || sif.playing !== 1'b0 || sif.done !== 1'b0) begin errors++; $display("FAIL prio_stop: hz %0d playing %b done %b want 0/0/0", sif.hz_next, sif.playing, sif.done); end
        pulse_play();
        checks++; if (sif.hz_next !== 12'd0 || sif.playing !== 1'b1) begin errors++; $display("FAIL prio_restart: hz %0d playing %b want 0/1", sif.hz_next, sif.playing); end
        step(2);
        checks++; if (sif.hz_next !== 12'd440) begin errors++; $display("FAIL prio_restart_note: got %0d want 440", sif.hz_next); end
        sif.stop = 1'b1;
        step(1);
        sif.stop = 1'b0;
    endtask

    task automatic test_reset_mid();
        int bad = 0;
        sif.song_sel = 2'd0;
        pulse_play();
        step(10);
        rst_n = 1'b0;
        step(1);
        checks++; if (sif.hz_next !== 12'd0 || sif.note_idx !== 6'd0) begin errors++; $display("FAIL rstmid_hz_note: hz %0d note %0d want 0/0", sif.hz_next, sif.note_idx); end
        checks++; if (sif.playing !== 1'b0 || sif.done !== 1'b0) begin errors++; $display("FAIL rstmid_flags: playing %b done %b want 0/0", sif.playing, sif.done); end
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (sif.done !== 1'b0 || sif.hz_next !== 12'd0) bad++;
            step(1);
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL rstmid_after: got %0d want 0", bad); end
    endtask

    initial begin
        sif.play = 1'b0; sif.pause = 1'b0; sif.stop = 1'b0; sif.loop = 1'b0;
        sif.song_sel = 2'd0; sif.tempo_sel = 2'd0;
        rst_n = 1'b0;
        step(1);
        test_reset();
        test_tempo(2'b00, 28, 34);
        test_tempo(2'b01, 13, 19);
        test_tempo(2'b10, 58, 64);
        test_tempo(2'b11, 28, 34);
        test_pause();
        test_loop();
        test_empty();
        test_rest();
        test_priority();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
